// File: rtl/ddr2_lfsr_pkg.sv
// Shared definitions for the DDR2 example driver's 8-bit LFSR pattern generator and checker.
// Polynomial x^8+x^4+x^3+x^2+1.
package ddr2_lfsr_pkg;

  localparam logic [7:0] LFSR8_DEFAULT_SEED = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } lfsr8_chk_state_e;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] d);
    return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
  endfunction

endpackage

// File: rtl/ddr2_lfsr8_err_capture.sv
// Saturating mismatch counter, first-error capture and pass flag for the LFSR8 checker.
// All outputs are registered; clear_i starts a fresh run.
module ddr2_lfsr8_err_capture (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        cmp_i,
  input  logic        mismatch_i,
  input  logic [7:0]  exp_i,
  input  logic [7:0]  rcv_i,
  input  logic [15:0] idx_i,
  output logic        err_pulse_o,
  output logic [15:0] err_count_o,
  output logic [7:0]  first_err_exp_o,
  output logic [7:0]  first_err_rcv_o,
  output logic [15:0] first_err_idx_o,
  output logic        pass_o
);

  logic        err_pulse_q, err_pulse_d;
  logic [15:0] err_count_q, err_count_d;
  logic [7:0]  first_exp_q, first_exp_d;
  logic [7:0]  first_rcv_q, first_rcv_d;
  logic [15:0] first_idx_q, first_idx_d;
  logic        pass_q, pass_d;

  always_comb begin
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    first_exp_d = first_exp_q;
    first_rcv_d = first_rcv_q;
    first_idx_d = first_idx_q;
    pass_d      = pass_q;
    if (clear_i) begin
      err_count_d = '0;
      first_exp_d = '0;
      first_rcv_d = '0;
      first_idx_d = '0;
      pass_d      = 1'b1;
    end else if (cmp_i && mismatch_i) begin
      err_pulse_d = 1'b1;
      pass_d      = 1'b0;
      // the count only reads zero before the first error of a run
      if (err_count_q == 16'h0000) begin
        first_exp_d = exp_i;
        first_rcv_d = rcv_i;
        first_idx_d = idx_i;
      end
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      first_exp_q <= '0;
      first_rcv_q <= '0;
      first_idx_q <= '0;
      pass_q      <= 1'b1;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      first_exp_q <= first_exp_d;
      first_rcv_q <= first_rcv_d;
      first_idx_q <= first_idx_d;
      pass_q      <= pass_d;
    end
  end

  assign err_pulse_o     = err_pulse_q;
  assign err_count_o     = err_count_q;
  assign first_err_exp_o = first_exp_q;
  assign first_err_rcv_o = first_rcv_q;
  assign first_err_idx_o = first_idx_q;
  assign pass_o          = pass_q;

endmodule

// File: rtl/ddr2_lfsr8_checker.sv
// Read-side LFSR8 pattern checker, one per byte lane. Build option LFSR8_CHK_RESYNC_EN
// re-locks the expected sequence from received data after RESYNC_THRESH consecutive mismatches.
//   state | meaning
//   IDLE  | disabled, expected held at SEED
//   CHECK | comparing read beats against the local sequence
//   DONE  | last beat seen, results frozen until enable drops
module ddr2_lfsr8_checker
  import ddr2_lfsr_pkg::*;
#(
  parameter logic [7:0]  SEED          = LFSR8_DEFAULT_SEED,
  parameter int unsigned RESYNC_THRESH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic [7:0]  ldata,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  output logic [7:0]  expected,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [15:0] beat_count,
  output logic [7:0]  first_err_exp,
  output logic [7:0]  first_err_rcv,
  output logic [15:0] first_err_idx,
  output logic        pass,
  output logic        done,
  output logic        resync_pulse
);

`ifdef LFSR8_CHK_RESYNC_EN
  localparam bit RESYNC_ON = 1'b1;
`else
  localparam bit RESYNC_ON = 1'b0;
`endif
  localparam logic [3:0] CONS_LAST = 4'(RESYNC_THRESH - 1);

  lfsr8_chk_state_e state_q, state_d;
  logic             enable_q;
  logic [7:0]       expected_q, expected_d;
  logic [15:0]      beat_count_q, beat_count_d;
  logic [3:0]       cons_q, cons_d;
  logic             resync_q, resync_d;
  logic             clear, cmp, mismatch, en_rise, resync_hit;

  assign mismatch   = (rx_data != expected_q);
  assign en_rise    = enable && !enable_q;
  assign resync_hit = RESYNC_ON && mismatch && (cons_q == CONS_LAST);

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    beat_count_d = beat_count_q;
    cons_d       = cons_q;
    resync_d     = 1'b0;
    clear        = 1'b0;
    cmp          = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      expected_d = SEED;
    end else if (en_rise) begin
      // a beat arriving with the enable edge is dropped on purpose
      state_d      = CHECK;
      expected_d   = SEED;
      beat_count_d = '0;
      cons_d       = '0;
      clear        = 1'b1;
    end else if (state_q == CHECK) begin
      if (load) begin
        expected_d = ldata;
      end else if (rx_valid) begin
        cmp = 1'b1;
        if (beat_count_q != 16'hFFFF) beat_count_d = beat_count_q + 16'h0001;
        if (!mismatch) begin
          expected_d = lfsr8_next(expected_q);
          cons_d     = '0;
        end else if (resync_hit) begin
          expected_d = lfsr8_next(rx_data);
          cons_d     = '0;
          resync_d   = 1'b1;
        end else begin
          expected_d = lfsr8_next(expected_q);
          if (cons_q != 4'hF) cons_d = cons_q + 4'h1;
        end
        if (rx_last) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      expected_q   <= SEED;
      beat_count_q <= '0;
      cons_q       <= '0;
      resync_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable;
      expected_q   <= expected_d;
      beat_count_q <= beat_count_d;
      cons_q       <= cons_d;
      resync_q     <= resync_d;
    end
  end

  ddr2_lfsr8_err_capture u_err_capture (
    .clk             (clk),
    .reset_n         (reset_n),
    .clear_i         (clear),
    .cmp_i           (cmp),
    .mismatch_i      (mismatch),
    .exp_i           (expected_q),
    .rcv_i           (rx_data),
    .idx_i           (beat_count_q),
    .err_pulse_o     (err_pulse),
    .err_count_o     (err_count),
    .first_err_exp_o (first_err_exp),
    .first_err_rcv_o (first_err_rcv),
    .first_err_idx_o (first_err_idx),
    .pass_o          (pass)
  );

  assign expected     = expected_q;
  assign beat_count   = beat_count_q;
  assign done         = (state_q == DONE);
  assign resync_pulse = resync_q;

endmodule

// File: doc/ddr2_lfsr8_checker.md
# ddr2_lfsr8_checker

Read-side companion to the DDR2 example driver's 8-bit LFSR pattern generator. Regenerates the same x^8+x^4+x^3+x^2+1 sequence locally from the same seed. Compares each returned read beat against it, and reports pass/fail, error count and the first failing beat. Sits on the read-data return path of the example driver, one instance per byte lane.

## Interface
- SEED, 8'h20, initial expected value; must equal the generator's seed.
- RESYNC_THRESH, 4, consecutive mismatches before resync (used only with resync compiled in); legal range 1..15.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  low: idle, expected forced to SEED; rising edge starts a new run.
- load  in  1  load expected from ldata (mirrors generator load).
- ldata  in  8  value loaded into the expected register.
- rx_valid  in  1  rx_data carries a read beat this cycle.
- rx_data  in  8  returned read byte.
- rx_last  in  1  qualifies the final beat of a run (with rx_valid).
- expected  out  8  current expected byte.
- err_pulse  out  1  one-cycle pulse per mismatching beat.
- err_count  out  16  mismatches this run, saturating at 16'hFFFF.
- beat_count  out  16  beats compared this run, saturating at 16'hFFFF.
- first_err_exp  out  8  expected byte of the first mismatch.
- first_err_rcv  out  8  received byte of the first mismatch.
- first_err_idx  out  16  beat_count value at the first mismatch (0-based).
- pass  out  1  high while err_count==0.
- done  out  1  high in DONE.
- resync_pulse  out  1  one-cycle pulse when resync occurs (tied 0 without resync).

## Operation
- Advance function next(d): n0=d7, n1=d0, n2=d1^d7, n3=d2^d7, n4=d3^d7, n5=d4, n6=d5, n7=d6.
- States: IDLE, CHECK, DONE.
- IDLE: expected=SEED. enable 0→1 moves to CHECK and clears err_count, beat_count, first_err_*, and the consecutive-mismatch count.
- CHECK, load=1: expected<=ldata. Any beat in the same cycle is discarded (not compared, not counted).
- CHECK, rx_valid=1, load=0: compare rx_data with expected.
  - Mismatch: err_pulse, err_count+1 (saturating). If this is the first error, capture first_err_exp, first_err_rcv and first_err_idx.
  - In all cases: beat_count+1 (saturating) and expected<=next(expected).
- CHECK, rx_valid=0: everything holds (equivalent of generator pause).
- rx_last with rx_valid in CHECK: the beat is compared normally, then the FSM moves to DONE.
- DONE: all counters and captures hold; further beats are ignored.
- enable=0 in any state returns the FSM to IDLE next cycle, with expected=SEED. Counters hold until the next enable rising edge so software can read them.
- Consecutive-mismatch counter (4 bits): clears on a match and saturates at 15.

## Timing
- Every output is registered. Compare result (err_pulse, counters, captures, expected advance) appears on the cycle after the rx_valid sample.
- Throughput: one beat per clock with no bubbles.
- Reset values: expected=SEED, state IDLE, pass=1, and all other outputs 0.
- Asynchronous reset mid-run aborts immediately; no partial state is retained.
- enable and rx_valid in the same cycle as the enable rising edge: the beat is ignored, and checking starts on the following cycle.

## Configuration
- LFSR8_CHK_RESYNC_EN defined: on the RESYNC_THRESH-th consecutive mismatch, expected<=next(rx_data) instead of next(expected). That beat still counts as an error. resync_pulse fires and the consecutive count clears. This lets the checker re-lock after dropped or extra beats.
- Not defined: expected always advances from itself, and resync_pulse is constant 0.

## Structure
- Shared package ddr2_lfsr_pkg holds:
  - function lfsr8_next, reused by the generator;
  - the state enum {IDLE, CHECK, DONE};
  - LFSR8_DEFAULT_SEED=8'h20.
- Sub-module ddr2_lfsr8_err_capture: saturating err_count, first-error capture and the pass flag.
- The FSM and expected register stay at top level.

## Test plan
- Reset, then enable, then beats 0x20,0x40,0x80,0x1D,0x3A with rx_last on the fifth beat -> err_count=0, beat_count=5, pass=1, done=1, no err_pulse.
- Same stream with the third beat 0x81 -> a single err_pulse, err_count=1, first_err_exp=0x80, first_err_rcv=0x81, first_err_idx=2, pass=0; beats 4 and 5 still match.
- rx_valid gaps of 3 idle cycles between beats -> expected holds across the gaps, and the results are identical to the first scenario.
- load=1 with ldata=0x80 and rx_valid in the same cycle -> that beat is discarded. The next beat 0x80 matches and the beat after that expects 0x1D.
- Resync macro defined with RESYNC_THRESH=4: the stream drops beat 0x40 -> 4 errors, then resync_pulse, after which subsequent beats match and err_count stays at 4. Without the macro, every following beat mismatches.
- Reset asserted mid-CHECK after 2 beats -> all outputs return to reset values immediately and expected=0x20.
